fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives next PC, issues instruction reads and fills IF/ID.
// Handles decode stalls and redirects, including ones that land mid-read.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INCR      = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        IFValid
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [31:0] buf_instr;
    logic [31:0] buf_instr_nxt;
    logic [31:0] buf_pc4;
    logic [31:0] buf_pc4_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        ifid_free;

    assign seq_pc    = PCResult + PC_INCR;
    assign target    = RedirectAddr & ~32'h3;
    assign ifid_free = !IFValid || !Stall;
    assign IMemAddr  = PCResult;
    assign IMemReq   = !Reset && (state != HOLD);

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        buf_instr_nxt = buf_instr;
        buf_pc4_nxt   = buf_pc4;
        instr_nxt     = Instruction;
        pc4_nxt       = PCPlus4;
        valid_nxt     = IFValid;
        Address       = PCResult;

        unique case (state)
            REQ: begin
                if (Redirect) begin
                    valid_nxt = 1'b0;
                    if (IMemRdy) begin
                        Address = target;
                    end else begin
                        // Read still in flight: park target until it retires
                        pending_nxt = target;
                        state_nxt   = DRAIN;
                    end
                end else if (IMemRdy) begin
                    Address = seq_pc;
                    if (ifid_free) begin
                        instr_nxt = IMemData;
                        pc4_nxt   = seq_pc;
                        valid_nxt = 1'b1;
                    end else begin
                        buf_instr_nxt = IMemData;
                        buf_pc4_nxt   = seq_pc;
                        state_nxt     = HOLD;
                    end
                end else if (!Stall) begin
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    Address   = target;
                    valid_nxt = 1'b0;
                    state_nxt = REQ;
                end else if (!Stall) begin
                    instr_nxt = buf_instr;
                    pc4_nxt   = buf_pc4;
                    valid_nxt = 1'b1;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                valid_nxt = 1'b0;
                if (IMemRdy) begin
                    Address   = Redirect ? target : pending;
                    state_nxt = REQ;
                end else if (Redirect) begin
                    pending_nxt = target;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase

        if (Reset) begin
            Address = RESET_VECTOR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= REQ;
            pending     <= '0;
            buf_instr   <= '0;
            buf_pc4     <= '0;
            Instruction <= '0;
            PCPlus4     <= '0;
            IFValid     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            buf_instr   <= buf_instr_nxt;
            buf_pc4     <= buf_pc4_nxt;
            Instruction <= instr_nxt;
            PCPlus4     <= pc4_nxt;
            IFValid     <= valid_nxt;
        end
    end

endmodule
